// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci/Galois LFSR with seed load and lock-up recovery
//
// Purpose:
//   Pseudo-random / test-pattern / scrambler-seed source. Configurable width, tap mask,
//   structure (Fibonacci or Galois) and feedback sense (XOR or XNOR). A clock enable advances
//   the register one step; a synchronous load forces a seed. If an enabled cycle finds the
//   register in the lock-up value it reloads INIT and pulses lockup.
//
// Optional feature:
//   `define LFSR_PERIOD_CNT_EN adds the period monitor (wrap pulse + period count).
//   Without it, wrap and period are tied to 0.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset (overrides load and en)
//   en      in   1      advance one step this cycle
//   load    in   1      load seed this cycle (overrides en)
//   seed    in   WIDTH  value loaded when load=1
//   out     out  WIDTH  current register state
//   lockup  out  1      one-cycle pulse: lock-up detected, INIT applied
//   wrap    out  1      one-cycle pulse: a step returned the state to its start value
//   period  out  WIDTH  number of steps in the last completed cycle
module lfsr_gen #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] TAPS      = 4'b1100,
  parameter bit               GALOIS    = 1'b0,
  parameter bit               XNOR_MODE = 1'b1,
  parameter logic [WIDTH-1:0] INIT      = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  // XNOR Fibonacci feedback can never leave all-ones; every XOR variant sticks at all-zeros.
  localparam logic [WIDTH-1:0] LOCK = (!GALOIS && XNOR_MODE) ? '1 : '0;

  if ((WIDTH < 2) || (WIDTH > 32)) begin : g_chk_width
    $error("lfsr_gen: WIDTH must be in 2..32");
  end
  if (!TAPS[WIDTH-1]) begin : g_chk_taps
    $error("lfsr_gen: TAPS[WIDTH-1] must be 1");
  end
  if (INIT == LOCK) begin : g_chk_init
    $error("lfsr_gen: INIT must differ from the lock-up value");
  end

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] galois_val;
  logic             fib_fb;
  logic             lock_hit;
  logic             step_taken;
  logic             recover_evt;

  // Next value of the shift register if a normal step is taken this cycle.
  always_comb begin
    fib_fb = ^(out_q & TAPS);
    if (XNOR_MODE) begin
      fib_fb = ~fib_fb;
    end
    // Galois: shift left, then fold the tap pattern back in when the MSB falls out.
    galois_val = {out_q[WIDTH-2:0], 1'b0} ^
                 (out_q[WIDTH-1] ? {TAPS[WIDTH-2:0], 1'b1} : {WIDTH{1'b0}});
    step_val   = GALOIS ? galois_val : {out_q[WIDTH-2:0], fib_fb};
  end

  assign lock_hit    = (out_q == LOCK);
  assign step_taken  = !load && en && !lock_hit;
  assign recover_evt = !load && en && lock_hit;

  // Next-state / next-value logic. The RECOVER state exists only for the single cycle after
  // INIT has been forced; it steps normally if enabled and always drops back to RUN.
  always_comb begin
    state_d = ST_RUN;
    out_d   = out_q;
    if (load) begin
      out_d = seed;
    end else if (recover_evt) begin
      out_d   = INIT;
      state_d = ST_RECOVER;
    end else if (step_taken) begin
      out_d = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      out_q   <= INIT;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out    = out_q;
  assign lockup = (state_q == ST_RECOVER);

`ifdef LFSR_PERIOD_CNT_EN
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] period_q;
  logic             wrap_q;
  logic             cnt_sat;

  assign cnt_sat = (cnt_q == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= INIT;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else if (load) begin
      start_q <= seed;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (recover_evt) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else if (step_taken) begin
      if (step_val == start_q) begin
        // This step completes the cycle, so it counts toward the reported period.
        wrap_q   <= 1'b1;
        period_q <= cnt_sat ? cnt_q : (cnt_q + ONE);
        cnt_q    <= '0;
      end else begin
        wrap_q <= 1'b0;
        cnt_q  <= cnt_sat ? cnt_q : (cnt_q + ONE);
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign wrap   = wrap_q;
  assign period = period_q;
`else
  assign wrap   = 1'b0;
  assign period = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed self-checking bench for lfsr_gen
module tb_lfsr_gen;

`ifdef LFSR_PERIOD_CNT_EN
  localparam bit PCNT = 1'b1;
`else
  localparam bit PCNT = 1'b0;
`endif

  logic       clk;
  logic       rst, en, load;
  logic [3:0] seed;
  logic [3:0] out;
  logic       lockup, wrap;
  logic [3:0] period;

  logic       rst8, en8, load8;
  logic [7:0] seed8;
  logic [7:0] out8;
  logic       lockup8, wrap8;
  logic [7:0] period8;

  int checks = 0;
  int errors = 0;

  lfsr_gen dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .seed  (seed),
    .out   (out),
    .lockup(lockup),
    .wrap  (wrap),
    .period(period)
  );

  lfsr_gen #(
    .WIDTH    (8),
    .TAPS     (8'hB8),
    .GALOIS   (1'b1),
    .XNOR_MODE(1'b0),
    .INIT     (8'h01)
  ) dut8 (
    .clk   (clk),
    .rst   (rst8),
    .en    (en8),
    .load  (load8),
    .seed  (seed8),
    .out   (out8),
    .lockup(lockup8),
    .wrap  (wrap8),
    .period(period8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] seq [15];
  bit         seen [256];
  int         dups;

  initial begin
    seq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
            4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
    rst = 1'b1; en = 1'b0; load = 1'b0; seed = 4'h0;
    rst8 = 1'b1; en8 = 1'b0; load8 = 1'b0; seed8 = 8'h00;

    // Reset state
    tick();
    chk("rst_out", out, 4'h0);
    chk("rst_lockup", lockup, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_period", period, 4'h0);
    chk("rst8_out", out8, 8'h01);

    // Full default sequence over 40 enabled steps
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("seq_out_%0d", k), out, seq[k % 15]);
      chk($sformatf("seq_wrap_%0d", k), wrap, PCNT && (k == 15 || k == 30));
      chk($sformatf("seq_period_%0d", k), period, (PCNT && k >= 15) ? 4'd15 : 4'd0);
      chk($sformatf("seq_lockup_%0d", k), lockup, 1'b0);
    end

    // Enable toggling from out=3
    rst = 1'b1; en = 1'b0; tick();
    rst = 1'b0; en = 1'b1; tick(); tick();
    chk("tog_start", out, 4'h3);
    en = 1'b1; tick(); chk("tog_en1", out, 4'h7);
    en = 1'b0; tick(); chk("tog_en0a", out, 4'h7);
    chk("tog_wrap0", wrap, 1'b0);
    tick(); chk("tog_en0b", out, 4'h7);
    en = 1'b1; tick(); chk("tog_en1b", out, 4'hE);

    // load beats en
    load = 1'b1; seed = 4'h5; en = 1'b1; tick();
    chk("load_en_out", out, 4'h5);
    chk("load_en_lockup", lockup, 1'b0);

    // Seed equal to the lock value, then recovery
    load = 1'b1; seed = 4'hF; en = 1'b0; tick();
    chk("lockseed_out", out, 4'hF);
    chk("lockseed_lockup", lockup, 1'b0);
    load = 1'b0; en = 1'b1; tick();
    chk("recover_out", out, 4'h0);
    chk("recover_lockup", lockup, 1'b1);
    tick();
    chk("after_rec_out1", out, 4'h1);
    chk("after_rec_lockup", lockup, 1'b0);
    tick(); chk("after_rec_out3", out, 4'h3);
    tick(); chk("after_rec_out7", out, 4'h7);

    // Mid-run reset at out=B
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("mid_at_B", out, 4'hB);
    rst = 1'b1; tick();
    chk("mid_rst_out", out, 4'h0);
    chk("mid_rst_lockup", lockup, 1'b0);
    rst = 1'b0; tick();
    chk("mid_resume", out, 4'h1);

    // rst beats load
    rst = 1'b1; load = 1'b1; seed = 4'h9; tick();
    chk("rst_over_load", out, 4'h0);
    rst = 1'b0; load = 1'b0; en = 1'b0;

    // 8-bit Galois: maximal-length cycle
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    dups = 0;
    rst8 = 1'b0; en8 = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (k == 8) chk("gal_step8", out8, 8'h71);
      if (k < 255) begin
        if (seen[out8] || out8 == 8'h00) dups++;
        seen[out8] = 1'b1;
      end
      if (k == 254) chk("gal_nowrap_254", wrap8, 1'b0);
    end
    chk("gal_distinct", dups, 0);
    chk("gal_return", out8, 8'h01);
    chk("gal_wrap", wrap8, PCNT);
    chk("gal_period", period8, PCNT ? 8'hFF : 8'h00);

    // Galois lock value (all-zeros) seed
    load8 = 1'b1; seed8 = 8'h00; en8 = 1'b0; tick();
    chk("gal_seed0", out8, 8'h00);
    load8 = 1'b0; en8 = 1'b1; tick();
    chk("gal_rec_out", out8, 8'h01);
    chk("gal_rec_lockup", lockup8, 1'b1);
    tick();
    chk("gal_rec_next", out8, 8'h02);
    chk("gal_rec_lockup0", lockup8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
